// File: rtl/opl3sw_pkg.sv
// Shared definitions for the software-OPL3 sample return path.
//   - mgmt register addresses (write side and read side share the bus)
//   - CTRL register bit positions
//   - opl3_frame_t: one stereo frame as stored in the FIFO
package opl3sw_pkg;

  localparam logic [7:0] OPL3SW_CTRL   = 8'd0;
  localparam logic [7:0] OPL3SW_LEFT   = 8'd1;
  localparam logic [7:0] OPL3SW_RIGHT  = 8'd2;
  localparam logic [7:0] OPL3SW_STATUS = 8'd0;
  localparam logic [7:0] OPL3SW_FREE   = 8'd1;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } opl3_frame_t;

endpackage

// File: rtl/opl3sw_frame_fifo.sv
// Synchronous show-ahead FIFO of stereo frames.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, din         write a frame (dropped when full unless popping)
//   pop               consume the head frame
//   flush             empty the FIFO; a push in the same cycle is discarded
//   dout              head frame, valid whenever empty is low
//   full, empty, used occupancy; used is DEPTH_LOG2+1 bits
module opl3sw_frame_fifo
  import opl3sw_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  opl3_frame_t         din,
  input  logic                pop,
  input  logic                flush,
  output opl3_frame_t         dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] used
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  opl3_frame_t mem [DEPTH];
  opl3_frame_t rd_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic wr_en;
  logic rd_en;

  // The RAM has a registered read port, so it is always addressed with the
  // pointer the head will have after this edge. That keeps rd_q equal to
  // the head frame without an extra cycle of latency.
  always_comb begin
    full  = (used == (DEPTH_LOG2 + 1)'(DEPTH));
    empty = (used == '0);
    rd_en = pop && !empty && !flush;
    wr_en = push && !flush && (!full || rd_en);
    if (flush) begin
      rd_addr = '0;
    end else if (rd_en) begin
      rd_addr = rd_ptr + (DEPTH_LOG2)'(1);
    end else begin
      rd_addr = rd_ptr;
    end
    dout = rd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (DEPTH_LOG2)'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + (DEPTH_LOG2)'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   used <= used + (DEPTH_LOG2 + 1)'(1);
        2'b01:   used <= used - (DEPTH_LOG2 + 1)'(1);
        default: used <= used;
      endcase
    end
  end

  // RAM reads old data on a same-address write, so a frame written into the
  // slot that becomes the head has to be forwarded around the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
    if (wr_en && (wr_ptr == rd_addr)) begin
      rd_q <= din;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/opl3sw_sample_out.sv
// Return path of the software-OPL3 bridge: host-rendered stereo frames are
// written over the mgmt bus, buffered, and released one per sample tick.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mgmt_address/write/writedata register writes (CTRL, LEFT, RIGHT)
//   mgmt_read, mgmt_readdata     registered reads (STATUS, FREE)
//   sample_l, sample_r           signed output frame
//   sample_strobe                one-cycle pulse per sample tick
//   fifo_low                     registered "used < LOW_WATER" request
module opl3sw_sample_out
  import opl3sw_pkg::*;
#(
  parameter int CLK_HZ     = 30000000,
  parameter int SAMPLE_HZ  = 49716,
  parameter int DEPTH_LOG2 = 8,
  parameter int LOW_WATER  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [15:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [15:0] mgmt_readdata,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_strobe,
  output logic        fifo_low
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                enable;
  logic                underrun;
  logic                overflow;
  logic [15:0]         staging_l;
  logic [31:0]         acc;
  logic [32:0]         acc_sum;
  logic                tick;
  logic                ctrl_wr;
  logic                left_wr;
  logic                right_wr;
  logic                flush;
  logic                clear_flags;
  logic                pop;
  logic                underrun_evt;
  logic                overflow_evt;
  opl3_frame_t         push_frame;
  opl3_frame_t         head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] used;
  logic [15:0]         status_word;
  logic [15:0]         free_word;

  // The accumulator sum is one bit wider so the compare against CLK_HZ
  // cannot be fooled by 32-bit wraparound.
  always_comb begin
    acc_sum      = {1'b0, acc} + 33'(SAMPLE_HZ);
    tick         = (acc_sum >= 33'(CLK_HZ));
    ctrl_wr      = mgmt_write && (mgmt_address == OPL3SW_CTRL);
    left_wr      = mgmt_write && (mgmt_address == OPL3SW_LEFT);
    right_wr     = mgmt_write && (mgmt_address == OPL3SW_RIGHT);
    flush        = ctrl_wr && mgmt_writedata[CTRL_FLUSH_BIT];
    clear_flags  = ctrl_wr && mgmt_writedata[CTRL_CLEAR_BIT];
    pop          = tick && enable && !fifo_empty;
    underrun_evt = tick && enable && fifo_empty;
    overflow_evt = right_wr && !flush && fifo_full && !pop;
    push_frame.l = staging_l;
    push_frame.r = mgmt_writedata;
    status_word  = {underrun, overflow, enable, 4'b0000, 9'(used)};
    free_word    = 16'(DEPTH) - 16'(used);
  end

  opl3sw_frame_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (right_wr),
    .din    (push_frame),
    .pop    (pop),
    .flush  (flush),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .used   (used)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (tick) begin
      acc <= 32'(acc_sum - 33'(CLK_HZ));
    end else begin
      acc <= acc_sum[31:0];
    end
  end

  // A flag-setting event in the same cycle as a clear request wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      staging_l <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= mgmt_writedata[CTRL_ENABLE_BIT];
      end
      if (flush) begin
        staging_l <= '0;
      end else if (left_wr) begin
        staging_l <= mgmt_writedata;
      end
      if (underrun_evt) begin
        underrun <= 1'b1;
      end else if (clear_flags) begin
        underrun <= 1'b0;
      end
      if (overflow_evt) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
    end
  end

  // On an enabled tick with an empty FIFO the previous frame is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_l      <= '0;
      sample_r      <= '0;
      sample_strobe <= 1'b0;
      fifo_low      <= 1'b1;
      mgmt_readdata <= '0;
    end else begin
      sample_strobe <= tick;
      fifo_low      <= (int'(used) < LOW_WATER);
      if (tick) begin
        if (!enable) begin
          sample_l <= '0;
          sample_r <= '0;
        end else if (!fifo_empty) begin
          sample_l <= head.l;
          sample_r <= head.r;
        end
      end
      if (mgmt_read) begin
        case (mgmt_address)
          OPL3SW_STATUS: mgmt_readdata <= status_word;
          OPL3SW_FREE:   mgmt_readdata <= free_word;
          default:       mgmt_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opl3sw_sample_out.sv
// Self-checking bench for opl3sw_sample_out with a small configuration
// (10 Hz clock, 1 Hz sample rate, 4-frame FIFO, low water 2).
module tb_opl3sw_sample_out;

  localparam int CLK_HZ     = 10;
  localparam int SAMPLE_HZ  = 1;
  localparam int DEPTH_LOG2 = 2;
  localparam int LOW_WATER  = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  mgmt_address;
  logic        mgmt_write;
  logic [15:0] mgmt_writedata;
  logic        mgmt_read;
  logic [15:0] mgmt_readdata;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_strobe;
  logic        fifo_low;

  int checks = 0;
  int errors = 0;

  // Reference model state: the FIFO is just a queue of {l, r} words.
  logic [31:0] m_q[$];
  logic [15:0] m_staging;
  logic        m_en;
  logic        m_und;
  logic        m_ovf;
  logic [15:0] m_l;
  logic [15:0] m_r;
  logic [15:0] m_rd;
  logic        m_strobe;
  logic        m_low;
  longint      m_k;

  opl3sw_sample_out #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ),
    .DEPTH_LOG2(DEPTH_LOG2),
    .LOW_WATER (LOW_WATER)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mgmt_address  (mgmt_address),
    .mgmt_write    (mgmt_write),
    .mgmt_writedata(mgmt_writedata),
    .mgmt_read     (mgmt_read),
    .mgmt_readdata (mgmt_readdata),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .sample_strobe (sample_strobe),
    .fifo_low      (fifo_low)
  );

  always #5 clk = ~clk;

  // Edge k (counted from reset release) is a tick edge when the ideal
  // sample count floor(t*SAMPLE_HZ/CLK_HZ) steps up across it.
  function automatic bit tickAt(input longint k);
    return ((k + 1) * SAMPLE_HZ) / CLK_HZ != (k * SAMPLE_HZ) / CLK_HZ;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_staging = '0;
    m_en      = 1'b0;
    m_und     = 1'b0;
    m_ovf     = 1'b0;
    m_l       = '0;
    m_r       = '0;
    m_rd      = '0;
    m_strobe  = 1'b0;
    m_low     = 1'b1;
    m_k       = 0;
  endtask

  // Advance the model across one clock edge given the bus inputs at that edge.
  task automatic modelStep(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [15:0] data);
    bit          tick;
    bit          und_evt;
    bit          ovf_evt;
    bit          clr;
    int          used;
    logic [31:0] head;
    tick    = tickAt(m_k);
    m_k++;
    und_evt = 1'b0;
    ovf_evt = 1'b0;
    clr     = 1'b0;
    used    = m_q.size();
    if (rd) begin
      if (addr == 8'd0)      m_rd = {m_und, m_ovf, m_en, 4'b0000, 9'(used)};
      else if (addr == 8'd1) m_rd = 16'(DEPTH - used);
      else                   m_rd = 16'h0000;
    end
    m_low    = (used < LOW_WATER);
    m_strobe = tick;
    if (tick) begin
      if (!m_en) begin
        m_l = '0;
        m_r = '0;
      end else if (used > 0) begin
        head = m_q.pop_front();
        m_l  = head[31:16];
        m_r  = head[15:0];
      end else begin
        und_evt = 1'b1;
      end
    end
    if (wr) begin
      if (addr == 8'd0) begin
        if (data[2]) begin
          m_q.delete();
          m_staging = '0;
        end
        clr  = data[1];
        m_en = data[0];
      end else if (addr == 8'd1) begin
        m_staging = data;
      end else if (addr == 8'd2) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_staging, data});
        else ovf_evt = 1'b1;
      end
    end
    m_und = und_evt || (m_und && !clr);
    m_ovf = ovf_evt || (m_ovf && !clr);
  endtask

  // Compare process: every edge after reset, check all outputs 1 time unit later.
  initial begin
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [15:0] data;
    modelReset();
    forever begin
      @(posedge clk);
      wr   = mgmt_write;
      rd   = mgmt_read;
      addr = mgmt_address;
      data = mgmt_writedata;
      if (!reset_n) begin
        modelReset();
      end else begin
        modelStep(wr, rd, addr, data);
        #1;
        checkOutput("model_sample_l", sample_l, m_l);
        checkOutput("model_sample_r", sample_r, m_r);
        checkOutput("model_strobe", {15'b0, sample_strobe}, {15'b0, m_strobe});
        checkOutput("model_fifo_low", {15'b0, fifo_low}, {15'b0, m_low});
        checkOutput("model_readdata", mgmt_readdata, m_rd);
      end
    end
  end

  // One bus cycle; starts and ends 2 time units after a rising edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input logic [15:0] data);
    mgmt_write     = wr;
    mgmt_read      = rd;
    mgmt_address   = addr;
    mgmt_writedata = data;
    @(posedge clk);
    #2;
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic readReg(input logic [7:0] addr);
    applyStimulus(1'b0, 1'b1, addr, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitTick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (sample_strobe === 1'b1) seen = 1'b1;
      #1;
    end
    checkOutput("tick_seen", {15'b0, seen}, 16'h0001);
  endtask

  // Idle until the next rising edge is a tick edge.
  task automatic waitTickEdge();
    for (int i = 0; i < 25 && !tickAt(m_k); i++) idle(1);
    checkOutput("tick_edge_found", {15'b0, tickAt(m_k)}, 16'h0001);
  endtask

  initial begin
    int r;
    int push_pct;
    reset_n        = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sample_l", sample_l, 16'h0000);
    checkOutput("reset_sample_r", sample_r, 16'h0000);
    checkOutput("reset_strobe", {15'b0, sample_strobe}, 16'h0000);
    checkOutput("reset_readdata", mgmt_readdata, 16'h0000);
    checkOutput("reset_fifo_low", {15'b0, fifo_low}, 16'h0001);
    #1;
    reset_n = 1'b1;

    $display("[TB] directed sequence");
    readReg(8'd0);
    checkOutput("status_after_reset", mgmt_readdata, 16'h0000);
    readReg(8'd1);
    checkOutput("free_after_reset", mgmt_readdata, 16'h0004);
    checkOutput("fifo_low_after_reset", {15'b0, fifo_low}, 16'h0001);
    waitTick();
    checkOutput("disabled_tick_l", sample_l, 16'h0000);
    checkOutput("disabled_tick_r", sample_r, 16'h0000);

    writeReg(8'd1, 16'h1234);
    writeReg(8'd2, 16'hFEDC);
    writeReg(8'd0, 16'h0001);
    waitTick();
    checkOutput("first_frame_l", sample_l, 16'h1234);
    checkOutput("first_frame_r", sample_r, 16'hFEDC);
    readReg(8'd0);
    checkOutput("status_after_pop", mgmt_readdata, 16'h2000);

    writeReg(8'd0, 16'h0000);
    writeReg(8'd1, 16'h1111);
    for (int i = 1; i <= 5; i++) writeReg(8'd2, 16'(i));
    readReg(8'd0);
    checkOutput("status_overflow", mgmt_readdata, 16'h4004);
    readReg(8'd1);
    checkOutput("free_when_full", mgmt_readdata, 16'h0000);

    writeReg(8'd0, 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      waitTick();
      checkOutput("order_l", sample_l, 16'h1111);
      checkOutput("order_r", sample_r, 16'(i));
    end
    waitTick();
    checkOutput("underrun_hold_r", sample_r, 16'h0004);
    readReg(8'd0);
    checkOutput("status_underrun", mgmt_readdata, 16'hE000);
    writeReg(8'd0, 16'h0003);
    readReg(8'd0);
    checkOutput("status_cleared", mgmt_readdata, 16'h2000);

    for (int i = 0; i < 4; i++) writeReg(8'd2, 16'h0011 + 16'(i));
    waitTickEdge();
    writeReg(8'd2, 16'h0015);
    readReg(8'd0);
    checkOutput("push_with_pop_status", mgmt_readdata, 16'h2004);
    checkOutput("push_with_pop_r", sample_r, 16'h0011);

    waitTick();
    checkOutput("before_flush_r", sample_r, 16'h0012);
    writeReg(8'd0, 16'h0005);
    checkOutput("fifo_low_lag", {15'b0, fifo_low}, 16'h0000);
    readReg(8'd0);
    checkOutput("status_after_flush", mgmt_readdata, 16'h2000);
    checkOutput("fifo_low_after_flush", {15'b0, fifo_low}, 16'h0001);
    waitTick();
    checkOutput("flush_hold_l", sample_l, 16'h1111);
    checkOutput("flush_hold_r", sample_r, 16'h0012);
    readReg(8'd0);
    checkOutput("status_flush_underrun", mgmt_readdata, 16'hA000);

    $display("[TB] random sequence");
    for (int phase = 0; phase < 3; phase++) begin
      push_pct = (phase == 0) ? 40 : (phase == 1) ? 8 : 20;
      for (int c = 0; c < 1200; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < push_pct) begin
          writeReg(8'd2, 16'($urandom()));
        end else if (r < push_pct + 10) begin
          writeReg(8'd1, 16'($urandom()));
        end else if (r < push_pct + 25) begin
          readReg(($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 1)));
        end else if (r < push_pct + 30) begin
          writeReg(8'd0, {13'($urandom()),
                          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0});
        end else if (r < push_pct + 32) begin
          writeReg(8'($urandom_range(3, 255)), 16'($urandom()));
        end else begin
          idle(1);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opl3sw_sample_out.md
Name: opl3sw_sample_out

Overview:
- Return path of the software-OPL3 bridge. Host software renders OPL3 audio frames from the dequeued register stream and writes them back through the same mgmt bus.
- The block buffers stereo frames in a FIFO and releases exactly one frame per OPL3 sample tick (49716 Hz nominal) to the sound mixer.
- It exposes fill, free-space and error status so software can pace rendering.

Parameters:
- CLK_HZ, 30000000, frequency of clk in Hz.
- SAMPLE_HZ, 49716, output frame rate in Hz.
- DEPTH_LOG2, 8, FIFO depth is 2^DEPTH_LOG2 stereo frames.
- LOW_WATER, 64, fifo_low asserts when used frames < LOW_WATER.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mgmt_address  in  8  register select.
- mgmt_write  in  1  write strobe, one cycle per access.
- mgmt_writedata  in  16  write data.
- mgmt_read  in  1  read strobe.
- mgmt_readdata  out  16  read data, registered.
- sample_l  out  16  left sample, signed two's complement.
- sample_r  out  16  right sample, signed.
- sample_strobe  out  1  one-cycle pulse when sample_l/sample_r update.
- fifo_low  out  1  level-sensitive request-for-data.

Behaviour:
- Clock and reset: single clock domain. On reset_n low, asynchronously:
  - clear FIFO, staging register, phase accumulator and sticky flags;
  - enable=0;
  - sample_l=sample_r=0, sample_strobe=0, mgmt_readdata=0, fifo_low=1.
- Register map, writes:
  - addr 0 CTRL: bit0 enable; bit1 clear sticky flags (self-clearing); bit2 flush (self-clearing).
  - addr 1 LEFT: load staging_l.
  - addr 2 RIGHT: push frame {staging_l, writedata} into the FIFO.
  - other addresses: ignored.
- Register map, reads (mgmt_readdata valid the cycle after mgmt_read; holds value otherwise):
  - addr 0 STATUS: {underrun, overflow, enable, 4'b0, used[8:0]}, with used zero-extended to 9 bits.
  - addr 1 FREE: free frame count.
  - others: 0.
- Push rules:
  - A push while full with no pop that cycle drops the frame and sets overflow sticky.
  - A push while full coincident with a pop is accepted.
  - The staging register is retained after a push, so repeated RIGHT writes reuse staging_l.
- Tick generator:
  - 32-bit phase accumulator advances by SAMPLE_HZ each cycle.
  - When acc+SAMPLE_HZ >= CLK_HZ: acc <= acc+SAMPLE_HZ-CLK_HZ and tick=1.
  - Average rate is exact with no long-term drift; jitter is at most 1 clk.
  - The accumulator runs regardless of enable.
- On tick with enable=1:
  - FIFO non-empty: pop head. sample_l/sample_r take the frame one cycle after the tick, with sample_strobe high in that same cycle. Tick-to-output latency is 1 cycle; FIFO read is show-ahead.
  - FIFO empty: outputs hold their last value, sample_strobe pulses, underrun sticky sets.
- On tick with enable=0: no pop; sample_l/sample_r forced to 0; sample_strobe still pulses.
- Flush: empties the FIFO and clears staging_l in the cycle after the write. It does not change outputs, enable or flags. A push in the same cycle as a flush is discarded.
- CTRL write with bit1 and an error event in the same cycle: the event wins and the flag stays set.
- Simultaneous push and pop: used count is unchanged.
- Pointers: wrap modulo depth. used is DEPTH_LOG2+1 bits to distinguish full from empty.
- fifo_low is registered and updates one cycle after the count changes.

Decomposition:
- Package opl3sw_pkg:
  - address constants OPL3SW_CTRL/LEFT/RIGHT/STATUS/FREE;
  - CTRL bit indices;
  - typedef opl3_frame_t as a packed struct {logic signed [15:0] l, r;}.
- Sub-module opl3sw_frame_fifo:
  - synchronous show-ahead FIFO of opl3_frame_t with push, pop, flush, full, empty and used ports;
  - inferred block RAM;
  - parameter DEPTH_LOG2.
- The top module holds the register decode, the phase accumulator and the output registers.

Test Plan (bench uses CLK_HZ=10, SAMPLE_HZ=1, DEPTH_LOG2=2, LOW_WATER=2):
- Reset, then read STATUS and FREE -> 0x0000 and 4; outputs 0; fifo_low=1. Ticks occur every 10 cycles with strobe high and outputs 0 (disabled).
- Write LEFT=0x1234, RIGHT=0xFEDC, CTRL=1, then wait for a tick -> one cycle after the tick sample_l=0x1234, sample_r=0xFEDC, strobe=1. Next STATUS used=0.
- Push 5 frames while enabled=0 -> used=4, FREE=0, STATUS bit14 (overflow)=1. The 5th frame is absent from the output order; frames 1–4 emerge in FIFO order after enable.
- Enable with the FIFO empty -> outputs hold the last frame, underrun bit15=1. CTRL=0x3 clears it -> STATUS reads 0x2000.
- Fill to 4 frames, then issue RIGHT in the same cycle as the tick pop -> push accepted, used stays 4, no overflow.
- Fill to 3 frames, then CTRL=0x5 (flush+enable) -> used=0, fifo_low=1 one cycle later. The next tick flags underrun and the outputs are unchanged.
